// File: rtl/comparator_1.sv
`default_nettype none
// ============================================================================
// Module      : comparator_1
// Description : Registered magnitude comparator for two WIDTH-bit operands.
//               One-hot less/great/eq flags appear one clock after a valid
//               sample; out_valid marks the cycle that follows each sample.
//               Optional build macro COMPARATOR_1_SIGNED_EN selects a two's
//               complement compare (MSB is the sign bit); without it the
//               compare is unsigned. Ports and latency are the same either way.
// Ports       : clk       in   rising-edge clock
//               rst       in   synchronous active-high reset
//               in_valid  in   a/b sampled on this edge
//               a, b      in   WIDTH-bit operands
//               less      out  a <  b for the last sampled pair
//               great     out  a >  b for the last sampled pair
//               eq        out  a == b for the last sampled pair
//               out_valid out  flags were updated by the previous edge
// Revision    : 1.0  initial release
// ============================================================================
module comparator_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             less,
    output logic             great,
    output logic             eq,
    output logic             out_valid
);

    logic w_less_d;
    logic w_great_d;
    logic w_eq_d;

    logic r_less_q;
    logic r_great_q;
    logic r_eq_q;
    logic r_valid_q;

`ifdef COMPARATOR_1_SIGNED_EN
    assign w_less_d  = ($signed(a) <  $signed(b));
    assign w_great_d = ($signed(a) >  $signed(b));
`else
    assign w_less_d  = (a <  b);
    assign w_great_d = (a >  b);
`endif
    assign w_eq_d    = (a == b);

    // Flags load only on a valid sample, so a/b (even X) cannot reach the
    // outputs while in_valid is low. Reset wins over a coincident sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_less_q  <= 1'b0;
            r_great_q <= 1'b0;
            r_eq_q    <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= in_valid;
            if (in_valid) begin
                r_less_q  <= w_less_d;
                r_great_q <= w_great_d;
                r_eq_q    <= w_eq_d;
            end
        end
    end

    assign less      = r_less_q;
    assign great     = r_great_q;
    assign eq        = r_eq_q;
    assign out_valid = r_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator_1.sv
`default_nettype none
// ============================================================================
// Module      : tb_comparator_1
// Description : Self-checking bench for comparator_1. Drives a WIDTH=1 and a
//               WIDTH=8 instance and compares against a numeric reference
//               model (two's complement when COMPARATOR_1_SIGNED_EN is set).
// Revision    : 1.0  initial release
// ============================================================================
module tb_comparator_1;

    logic       clk;
    logic       rst;

    logic       v1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       less1, great1, eq1, ov1;

    logic       v8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       less8, great8, eq8, ov8;

    int errors;
    int checks;

    comparator_1 #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .less      (less1),
        .great     (great1),
        .eq        (eq1),
        .out_valid (ov1)
    );

    comparator_1 #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .a         (a8),
        .b         (b8),
        .less      (less8),
        .great     (great8),
        .eq        (eq8),
        .out_valid (ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: interpret operands as integers, then compare. Returns
    // {less, great, eq}.
    function automatic logic [2:0] ref_cmp(input longint av, input longint bv, input int w);
        longint sa;
        longint sb;
        sa = av;
        sb = bv;
`ifdef COMPARATOR_1_SIGNED_EN
        if (av >= (64'sd1 <<< (w - 1))) sa = av - (64'sd1 <<< w);
        if (bv >= (64'sd1 <<< (w - 1))) sb = bv - (64'sd1 <<< w);
`endif
        return {sa < sb, sa > sb, sa == sb};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({less1, great1, eq1, ov1} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_w1 cyc%0d: got %b want 0000", i, {less1, great1, eq1, ov1});
            end
            checks++;
            if ({less8, great8, eq8, ov8} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_w8 cyc%0d: got %b want 0000", i, {less8, great8, eq8, ov8});
            end
            @(negedge clk);
        end
        rst = 1'b0;
        v1 = 1'b0;
        v8 = 1'b0;
    endtask

    task automatic test_w1_sequence();
        logic [2:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v1 = 1'b1;
            a1 = 1'((i >> 1) & 1);
            b1 = 1'(i & 1);
            exp = ref_cmp(longint'(a1), longint'(b1), 1);
            @(posedge clk); #1;
            checks++;
            if ({less1, great1, eq1, ov1} !== {exp, 1'b1}) begin
                errors++;
                $display("FAIL w1_seq a=%0d b=%0d: got %b want %b", a1, b1,
                         {less1, great1, eq1, ov1}, {exp, 1'b1});
            end
            checks++;
            if ($countones({less1, great1, eq1}) != 1) begin
                errors++;
                $display("FAIL w1_onehot: got %b want one-hot", {less1, great1, eq1});
            end
        end
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_hold();
        logic [2:0] held;
        @(negedge clk);
        v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        held = ref_cmp(0, 1, 1);
        @(posedge clk); #1;
        checks++;
        if ({less1, great1, eq1, ov1} !== {held, 1'b1}) begin
            errors++;
            $display("FAIL hold_sample: got %b want %b", {less1, great1, eq1, ov1}, {held, 1'b1});
        end
        @(negedge clk);
        v1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({less1, great1, eq1, ov1} !== {held, 1'b0}) begin
                errors++;
                $display("FAIL hold_idle cyc%0d: got %b want %b", i,
                         {less1, great1, eq1, ov1}, {held, 1'b0});
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] exp;
        @(negedge clk);
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        exp = ref_cmp(1, 0, 1);
        @(posedge clk); #1;
        checks++;
        if ({less1, great1, eq1, ov1} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL midrst_sample: got %b want %b", {less1, great1, eq1, ov1}, {exp, 1'b1});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({less1, great1, eq1, ov1} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_clear: got %b want 0000", {less1, great1, eq1, ov1});
        end
        @(negedge clk);
        rst = 1'b0; a1 = 1'b0; b1 = 1'b0;
        exp = ref_cmp(0, 0, 1);
        @(posedge clk); #1;
        checks++;
        if ({less1, great1, eq1, ov1} !== {exp, 1'b1}) begin
            errors++;
            $display("FAIL midrst_resume: got %b want %b", {less1, great1, eq1, ov1}, {exp, 1'b1});
        end
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic test_w8_boundary();
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic [2:0] exp;
        ta[0] = 8'hFF; tb[0] = 8'h00;
        ta[1] = 8'h7F; tb[1] = 8'h80;
        ta[2] = 8'hA5; tb[2] = 8'hA5;
        ta[3] = 8'hFF; tb[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v8 = 1'b1; a8 = ta[i]; b8 = tb[i];
            exp = ref_cmp(longint'(ta[i]), longint'(tb[i]), 8);
            @(posedge clk); #1;
            checks++;
            if ({less8, great8, eq8, ov8} !== {exp, 1'b1}) begin
                errors++;
                $display("FAIL w8_bound a=%h b=%h: got %b want %b", ta[i], tb[i],
                         {less8, great8, eq8, ov8}, {exp, 1'b1});
            end
        end
        @(negedge clk);
        v8 = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] h1;
        logic [2:0] h8;
        logic       e1v;
        logic       e8v;
        h1 = {less1, great1, eq1};
        h8 = {less8, great8, eq8};
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            v1 = 1'($urandom_range(0, 1));
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            v8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b8 = a8;
            if (v1) h1 = ref_cmp(longint'(a1), longint'(b1), 1);
            if (v8) h8 = ref_cmp(longint'(a8), longint'(b8), 8);
            e1v = v1;
            e8v = v8;
            @(posedge clk); #1;
            checks++;
            if ({less1, great1, eq1, ov1} !== {h1, e1v}) begin
                errors++;
                $display("FAIL rand_w1 it%0d: got %b want %b", i, {less1, great1, eq1, ov1}, {h1, e1v});
            end
            checks++;
            if ({less8, great8, eq8, ov8} !== {h8, e8v}) begin
                errors++;
                $display("FAIL rand_w8 it%0d: got %b want %b", i, {less8, great8, eq8, ov8}, {h8, e8v});
            end
            if (ov8) begin
                checks++;
                if ($countones({less8, great8, eq8}) != 1) begin
                    errors++;
                    $display("FAIL w8_onehot it%0d: got %b want one-hot", i, {less8, great8, eq8});
                end
            end
        end
        @(negedge clk);
        v1 = 1'b0;
        v8 = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        test_reset();
        test_w1_sequence();
        test_hold();
        test_mid_reset();
        test_w8_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
